stopwatch_lap_ctrl: RTL

- Stopwatch controller with lap-freeze. Sits downstream of the watch clock generator and consumes its 10 ms tick pulse.
- Takes single-cycle button pulses from the debounce/edge-detect stage.
- Keeps a BCD minute/second/centisecond count and drives a 4-digit BCD word to the FND scan driver.

---
 rtl/stopwatch_lap_ctrl_pkg.sv | 49 ++++
 rtl/stopwatch_lap_ctrl_bcd_chain.sv | 60 ++++++
 rtl/stopwatch_lap_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared types and constants for the stopwatch: FSM encoding, BCD digit limits
// and the 16-bit display-word layout also used by the FND scan driver.
package stopwatch_lap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   localparam int CSEC_MAX = 99;
   localparam int SEC_MAX  = 59;
   localparam logic [7:0] CSEC_MAX_BCD = 8'h99;
   localparam logic [7:0] SEC_MAX_BCD  = 8'h59;

   localparam int DIGIT_W     = 4;
   localparam int DISP_D3_LSB = 12;
   localparam int DISP_D2_LSB = 8;
   localparam int DISP_D1_LSB = 4;
   localparam int DISP_D0_LSB = 0;

   typedef struct packed {
      logic [3:0] min10;
      logic [3:0] min1;
      logic [3:0] sec10;
      logic [3:0] sec1;
      logic [3:0] csec10;
      logic [3:0] csec1;
   } sw_time_t;

   // show_min=0 -> ss.cc, show_min=1 -> mm.ss
   function automatic logic [15:0] disp_word(input sw_time_t t, input logic show_min);
      logic [15:0] w;
      w = '0;
      if (show_min) begin
         w[DISP_D3_LSB +: DIGIT_W] = t.min10;
         w[DISP_D2_LSB +: DIGIT_W] = t.min1;
         w[DISP_D1_LSB +: DIGIT_W] = t.sec10;
         w[DISP_D0_LSB +: DIGIT_W] = t.sec1;
      end else begin
         w[DISP_D3_LSB +: DIGIT_W] = t.sec10;
         w[DISP_D2_LSB +: DIGIT_W] = t.sec1;
         w[DISP_D1_LSB +: DIGIT_W] = t.csec10;
         w[DISP_D0_LSB +: DIGIT_W] = t.csec1;
      end
      return w;
   endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_bcd_chain.sv
// BCD mm:ss.cc cascade with carry and saturation at max_min:59.99.
module stopwatch_bcd_chain
   import stopwatch_lap_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset_p,
   input  logic               inc,
   input  logic               clr,
   input  logic [7:0]         max_min,
   output logic [DIGIT_W-1:0] csec1,
   output logic [DIGIT_W-1:0] csec10,
   output logic [DIGIT_W-1:0] sec1,
   output logic [DIGIT_W-1:0] sec10,
   output logic [DIGIT_W-1:0] min1,
   output logic [DIGIT_W-1:0] min10,
   output logic               at_max
);

   localparam logic [3:0] UNIT_LIM   = 4'd9;
   localparam logic [3:0] CSEC10_LIM = 4'(CSEC_MAX / 10);
   localparam logic [3:0] SEC10_LIM  = 4'(SEC_MAX / 10);

   assign at_max = ({min10, min1} == max_min) && ({sec10, sec1} == SEC_MAX_BCD) &&
                   ({csec10, csec1} == CSEC_MAX_BCD);

   always_ff @(posedge clk) begin
      if (reset_p || clr) begin
         csec1  <= '0;
         csec10 <= '0;
         sec1   <= '0;
         sec10  <= '0;
         min1   <= '0;
         min10  <= '0;
      end else if (inc && !at_max) begin
         // Each digit rolls to 0 at its limit and hands the carry to the next one up.
         if (csec1 != UNIT_LIM) csec1 <= csec1 + 4'd1;
         else begin
            csec1 <= '0;
            if (csec10 != CSEC10_LIM) csec10 <= csec10 + 4'd1;
            else begin
               csec10 <= '0;
               if (sec1 != UNIT_LIM) sec1 <= sec1 + 4'd1;
               else begin
                  sec1 <= '0;
                  if (sec10 != SEC10_LIM) sec10 <= sec10 + 4'd1;
                  else begin
                     sec10 <= '0;
                     if (min1 != UNIT_LIM) min1 <= min1 + 4'd1;
                     else begin
                        min1  <= '0;
                        min10 <= min10 + 4'd1;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, lap-freeze register and the
// registered 4-digit display mux feeding the FND scan driver.
module stopwatch_lap_ctrl
   import stopwatch_lap_ctrl_pkg::*;
#(
   parameter int MAX_MIN = 59
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        clk_10msec,
   input  logic        btn_start,
   input  logic        btn_lap,
   input  logic        btn_clear,
   input  logic        mode_sel,
   output logic [15:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   sw_state_t  state;
   sw_time_t   live;
   sw_time_t   lap_q;
   logic       at_max;
   logic       tick_run;
   logic       clr_cnt;
   logic [7:0] max_min_bcd;

   assign max_min_bcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   assign tick_run    = clk_10msec && (state == ST_RUN);
   assign clr_cnt     = btn_clear && (state != ST_RUN);

   stopwatch_bcd_chain u_chain (
      .clk     (clk),
      .reset_p (reset_p),
      .inc     (tick_run),
      .clr     (clr_cnt),
      .max_min (max_min_bcd),
      .csec1   (live.csec1),
      .csec10  (live.csec10),
      .sec1    (live.sec1),
      .sec10   (live.sec10),
      .min1    (live.min1),
      .min10   (live.min10),
      .at_max  (at_max)
   );

   always_ff @(posedge clk) begin
      if (reset_p) begin
         state      <= ST_IDLE;
         running    <= 1'b0;
         lap_active <= 1'b0;
         overflow   <= 1'b0;
         lap_q      <= '0;
         disp_bcd   <= '0;
      end else begin
         // Display follows the registers as they stood before this edge.
         disp_bcd <= disp_word(lap_active ? lap_q : live, mode_sel);
         case (state)
            ST_IDLE: begin
               if (!btn_clear && btn_start) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (tick_run && at_max) begin
                  state    <= ST_PAUSE;
                  running  <= 1'b0;
                  overflow <= 1'b1;
               end else if (btn_start) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end
               // Lap captures the count as it was before any same-cycle tick.
               if (!btn_start && btn_lap) begin
                  if (!lap_active) lap_q <= live;
                  lap_active <= !lap_active;
               end
            end
            ST_PAUSE: begin
               if (btn_clear) begin
                  state      <= ST_IDLE;
                  lap_active <= 1'b0;
                  overflow   <= 1'b0;
               end else if (btn_start && !overflow) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end else if (btn_lap) begin
                  lap_active <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule
